// File: rtl/uart_tx_if.sv
// uart_tx_if: byte-side handshake and serial outputs of the UART transmitter.
//
// Signals:
//   T_in   [7:0] byte offered by user logic
//   load         write strobe, taken only while tready=1
//   tready       holding register empty
//   tdata        serial line, idle high
//   tbusy        a frame is on the line
//   tdone        one-clock pulse at the end of each stop bit
//
// master: user logic (drives T_in/load, observes status and line)
// slave:  the transmitter itself
interface uart_tx_if;
    logic [7:0] T_in;
    logic       load;
    logic       tready;
    logic       tdata;
    logic       tbusy;
    logic       tdone;

    modport master (
        output T_in,
        output load,
        input  tready,
        input  tdata,
        input  tbusy,
        input  tdone
    );

    modport slave (
        input  T_in,
        input  load,
        output tready,
        output tdata,
        output tbusy,
        output tdone
    );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with a one-deep holding register.
//
// A byte written through the bus is parked in the holding register and
// drained into the shift register when the line is free (from IDLE, or
// straight out of the stop bit for gap-free back-to-back frames). Bit
// timing is a divide-by-DIVVALUE baud x8 tick used as a clock enable;
// each bit lasts 8 ticks, i.e. 8*DIVVALUE clocks.
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-low reset; discards any frame and held byte
//   bus   uart_tx_if.slave (T_in, load, tready, tdata, tbusy, tdone)
//
// Parameters:
//   DIVVALUE  clk cycles per baud x8 tick, >= 2
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | line high, waiting for the holding register
// START | start bit (line low) for 8 ticks
// DATA  | data bits LSB first, 8 ticks each
// STOP  | stop bit (line high) for 8 ticks, tdone at end
module uart_tx #(
    parameter int DIVVALUE = 27
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  bus
);

    localparam int DW = (DIVVALUE > 1) ? $clog2(DIVVALUE) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIVVALUE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state;
    logic [7:0]      hold;
    logic            hold_full;
    logic [7:0]      shift;
    logic [DW-1:0]   div_cnt;
    logic [2:0]      tick_cnt;
    logic [2:0]      bit_idx;
    logic            tdata_q;
    logic            tbusy_q;
    logic            tdone_q;

    logic            tick;
    logic            bit_end;

    // Tick fires on the divider wrap; a bit ends on the 8th tick.
    assign tick    = (div_cnt == DIV_LAST);
    assign bit_end = tick && (tick_cnt == 3'd7);

    assign bus.tready = ~hold_full;
    assign bus.tdata  = tdata_q;
    assign bus.tbusy  = tbusy_q;
    assign bus.tdone  = tdone_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            hold      <= 8'h00;
            hold_full <= 1'b0;
            shift     <= 8'h00;
            div_cnt   <= '0;
            tick_cnt  <= 3'd0;
            bit_idx   <= 3'd0;
            tdata_q   <= 1'b1;
            tbusy_q   <= 1'b0;
            tdone_q   <= 1'b0;
        end else begin
            tdone_q <= 1'b0;

            // Accept only into an empty holding register. A drain below
            // needs hold_full=1, so the two never collide on one edge.
            if (bus.load && !hold_full) begin
                hold      <= bus.T_in;
                hold_full <= 1'b1;
            end

            // Divider and tick counter run in every non-IDLE state.
            if (state != IDLE) begin
                if (tick) begin
                    div_cnt  <= '0;
                    tick_cnt <= tick_cnt + 3'd1;
                end else begin
                    div_cnt  <= div_cnt + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    div_cnt  <= '0;
                    tick_cnt <= 3'd0;
                    tdata_q  <= 1'b1;
                    tbusy_q  <= 1'b0;
                    if (hold_full) begin
                        state     <= START;
                        shift     <= hold;
                        hold_full <= 1'b0;
                        bit_idx   <= 3'd0;
                        tdata_q   <= 1'b0;
                        tbusy_q   <= 1'b1;
                    end
                end

                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        bit_idx <= 3'd0;
                        tdata_q <= shift[0];
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        shift   <= {1'b0, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state   <= STOP;
                            tdata_q <= 1'b1;
                        end else begin
                            // Next bit is the one about to land in shift[0].
                            tdata_q <= shift[1];
                        end
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        tdone_q <= 1'b1;
                        if (hold_full) begin
                            // Back-to-back: next start bit with no idle gap.
                            state     <= START;
                            shift     <= hold;
                            hold_full <= 1'b0;
                            div_cnt   <= '0;
                            tick_cnt  <= 3'd0;
                            bit_idx   <= 3'd0;
                            tdata_q   <= 1'b0;
                            tbusy_q   <= 1'b1;
                        end else begin
                            state   <= IDLE;
                            tdata_q <= 1'b1;
                            tbusy_q <= 1'b0;
                        end
                    end
                end

                default: begin
                    state   <= IDLE;
                    tdata_q <= 1'b1;
                    tbusy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
